ram_read_sequencer: RTL
=======================

RAM_READ_SEQUENCER -- requirements
Module: ram_read_sequencer

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, 11, RAM address width.
- KERNEL, 5, window edge length.
- WEIGHT_COUNT, 25, number of weight words per preload.
- RD_LAT, 1, RAM read latency in cycles.
- WGAP, 2, idle cycles between the end of weight preload and the start of inference.
- PIPE_LAT, 18, cycles from a pixel read to its window being present at the delay-line outputs.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request.
- cfg_mode  in  3  feature-map select: 0=32, 1=28, 2=14, 3=10, 4=5; values 5-7 are illegal.
- cfg_load_w  in  1  1 = run the weight preload before inference.
- cfg_base  in  ADDR_WIDTH  feature-map base address.
- cfg_wbase  in  ADDR_WIDTH  weight base address.
- hold  in  1  stall request.
- read_addr  out  ADDR_WIDTH  RAM read address.
- en  out  1  RAM read enable.
- WorI  out  1  1 = weight read, 0 = inference read.
- mode  out  3  latched cfg_mode, drives the line buffer.
- weight_valid  out  1  weight word is valid on the datapath this cycle.
- win_valid  out  1  a complete KERNELxKERNEL window is valid this cycle.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- cfg_err  out  1  one-cycle pulse on an illegal start.

Function
REQ-003 The block SHALL implement the states IDLE, WLOAD, WGAP, INFER, DRAIN and DONE.
REQ-004 IDLE behaviour on start:
- With a legal cfg_mode, the block SHALL latch all cfg_* inputs, set busy on the next cycle, and go to WLOAD if cfg_load_w=1, otherwise to INFER.
- With an illegal cfg_mode, it SHALL pulse cfg_err for one cycle and stay in IDLE.
REQ-005 start SHALL be ignored in every state except IDLE.
REQ-006 WLOAD SHALL present read_addr = wbase+k with en=1 and WorI=1 for k = 0..WEIGHT_COUNT-1, one address per un-held cycle.
REQ-007 weight_valid SHALL assert exactly RD_LAT cycles after each WLOAD read cycle with en=1.
REQ-008 WGAP SHALL last WGAP cycles with en=0 and WorI=1, then enter INFER with WorI=0.
REQ-009 INFER SHALL read the SxS map in raster order:
- read_addr = base + r*S + c, with c the fastest-varying index.
- Addresses SHALL be generated with incrementing counters, not a multiplier.
- Addresses wrap modulo 2^ADDR_WIDTH.
REQ-010 While hold=1 in WLOAD or INFER, en SHALL be 0 and read_addr and all counters SHALL freeze. hold SHALL be ignored in every other state.
REQ-011 Each INFER read cycle with en=1 SHALL insert a tag into a PIPE_LAT-deep shift register that advances every cycle regardless of hold:
- The tag is 1 iff r >= KERNEL-1 and c >= KERNEL-1.
- Non-read cycles insert 0.
- win_valid SHALL equal the register output, so it asserts exactly PIPE_LAT cycles after the qualifying read.
REQ-012 After the last INFER read (r=c=S-1), the block SHALL enter DRAIN for PIPE_LAT cycles with en=0, then DONE.
REQ-013 DONE SHALL pulse done for one cycle, clear busy in the same cycle, and return to IDLE.
REQ-014 mode SHALL hold the latched cfg_mode from the start acceptance until the next accepted start.
REQ-015 Outside WLOAD and INFER, en SHALL be 0 and read_addr SHALL hold its last value.
REQ-016 If S < KERNEL, the job SHALL still run to completion with zero win_valid pulses. This case is unreachable with legal modes.

Reset
REQ-017 While rst=1 at a clock edge, the block SHALL:
- go to IDLE;
- set read_addr=0, en=0, WorI=0, mode=0, weight_valid=0, win_valid=0, busy=0, done=0 and cfg_err=0;
- clear the tag and weight-valid pipelines.
REQ-018 A reset asserted mid-job SHALL abort the job with no done pulse and no later win_valid or weight_valid pulses.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- mode 4, base 0x100, no weights, hold=0 -> 25 reads at 0x100..0x118 on consecutive cycles; one win_valid, 18 cycles after the 0x118 read; done 19 cycles after the 0x118 read.
- mode 3, base 0 -> 100 reads and exactly 36 win_valid pulses.
- cfg_load_w=1, wbase 0x700, mode 0 -> 25 reads at 0x700..0x718 with WorI=1; 25 weight_valid pulses; 2 gap cycles with en=0; 1024 inference reads and 784 win_valid pulses.
- hold=1 for 3 cycles during the INFER read of row 2 col 7 -> en=0 for those 3 cycles with address frozen; win_valid count is unchanged and each pulse shifts 3 cycles later.
- cfg_mode=6 with start -> one cfg_err pulse, busy stays 0 and no reads are issued; start while busy -> ignored.
- base 0x7F0, mode 4 -> addresses wrap 0x7FF -> 0x000; rst=1 during INFER -> all outputs 0 next cycle and no done pulse.

Source files
------------

// File: rtl/ram_read_sequencer.sv
// Read-address sequencer for a windowed feature-map engine: optional weight preload,
// raster-order map reads, and a tag pipeline that marks when a full window is available.
module ram_read_sequencer #(
    parameter int ADDR_WIDTH   = 11,
    parameter int KERNEL       = 5,
    parameter int WEIGHT_COUNT = 25,
    parameter int RD_LAT       = 1,
    parameter int WGAP         = 2,
    parameter int PIPE_LAT     = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            cfg_mode,
    input  logic                  cfg_load_w,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_wbase,
    input  logic                  hold,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  en,
    output logic                  WorI,
    output logic [2:0]            mode,
    output logic                  weight_valid,
    output logic                  win_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    // state   | meaning
    // IDLE    | waiting for start
    // WLOAD   | reading WEIGHT_COUNT weight words
    // WGAP    | idle gap between weight preload and inference
    // INFER   | raster read of the SxS feature map
    // DRAIN   | letting the last window tags flush out of the pipeline
    // DONE    | one-cycle completion pulse
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WLOAD = 3'd1;
    localparam logic [2:0] S_WGAP  = 3'd2;
    localparam logic [2:0] S_INFER = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int TMAX0 = (WEIGHT_COUNT > PIPE_LAT) ? WEIGHT_COUNT : PIPE_LAT;
    localparam int TMAX1 = (TMAX0 > WGAP) ? TMAX0 : WGAP;
    localparam int TMAX  = (TMAX1 > 2) ? TMAX1 : 2;
    localparam int CW    = $clog2(TMAX);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [2:0]            mode_q, mode_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [5:0]            row_q, row_d;
    logic [5:0]            col_q, col_d;
    logic [PIPE_LAT-1:0]   tag_q, tag_d;
    logic [RD_LAT-1:0]     wv_q, wv_d;
    logic                  err_q, err_d;
    logic                  tag_in;
    logic                  wv_in;
    logic [5:0]            side_m1;

    always_comb begin
        case (mode_q)
            3'd0:    side_m1 = 6'd31;
            3'd1:    side_m1 = 6'd27;
            3'd2:    side_m1 = 6'd13;
            3'd3:    side_m1 = 6'd9;
            default: side_m1 = 6'd4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        err_d   = 1'b0;
        tag_in  = 1'b0;
        wv_in   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_mode <= 3'd4) begin
                        mode_d = cfg_mode;
                        base_d = cfg_base;
                        row_d  = 6'd0;
                        col_d  = 6'd0;
                        if (cfg_load_w) begin
                            state_d = S_WLOAD;
                            addr_d  = cfg_wbase;
                            cnt_d   = CW'(WEIGHT_COUNT - 1);
                        end else begin
                            state_d = S_INFER;
                            addr_d  = cfg_base;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WLOAD: begin
                if (!hold) begin
                    wv_in = 1'b1;
                    if (cnt_q == '0) begin
                        if (WGAP == 0) begin
                            state_d = S_INFER;
                            addr_d  = base_q;
                        end else begin
                            state_d = S_WGAP;
                            cnt_d   = CW'(WGAP - 1);
                        end
                    end else begin
                        cnt_d  = cnt_q - 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_WGAP: begin
                if (cnt_q == '0) begin
                    state_d = S_INFER;
                    addr_d  = base_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_INFER: begin
                if (!hold) begin
                    // raster order over a contiguous map: the address just steps by one
                    tag_in = (row_q >= 6'(KERNEL - 1)) && (col_q >= 6'(KERNEL - 1));
                    if (col_q == side_m1) begin
                        col_d = 6'd0;
                        if (row_q == side_m1) begin
                            state_d = S_DRAIN;
                            cnt_d   = CW'(PIPE_LAT - 1);
                        end else begin
                            row_d  = row_q + 6'd1;
                            addr_d = addr_q + 1'b1;
                        end
                    end else begin
                        col_d  = col_q + 6'd1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        tag_d = (tag_q << 1) | PIPE_LAT'(tag_in);
        wv_d  = (wv_q << 1) | RD_LAT'(wv_in);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            mode_q  <= 3'd0;
            cnt_q   <= '0;
            row_q   <= 6'd0;
            col_q   <= 6'd0;
            tag_q   <= '0;
            wv_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tag_q   <= tag_d;
            wv_q    <= wv_d;
            err_q   <= err_d;
        end
    end

    assign read_addr    = addr_q;
    assign en           = ((state_q == S_WLOAD) || (state_q == S_INFER)) && !hold;
    assign WorI         = (state_q == S_WLOAD) || (state_q == S_WGAP);
    assign mode         = mode_q;
    assign weight_valid = wv_q[RD_LAT-1];
    assign win_valid    = tag_q[PIPE_LAT-1];
    assign busy         = (state_q == S_WLOAD) || (state_q == S_WGAP) ||
                          (state_q == S_INFER) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign cfg_err      = err_q;

endmodule
